// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains length-prefixed packets from a FIFO onto a valid/ready stream.
// Optional starvation abort in PAY is enabled by defining PKT_TIMEOUT_EN.
module fifo_pkt_reader #(
   parameter int DT_WIDTH    = 8,
   parameter int CNT_WIDTH   = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [DT_WIDTH-1:0]  fifo_rd_dt,
   output logic                 fifo_rd_en,
   output logic [DT_WIDTH-1:0]  out_dt,
   output logic                 out_vld,
   output logic                 out_last,
   input  logic                 out_rdy,
   output logic                 busy,
   output logic                 drop_pulse,
   output logic                 timeout_err,
   output logic [CNT_WIDTH-1:0] pkt_cnt
);
   typedef enum logic {HDR, PAY} state_t;
   state_t state;
   logic [DT_WIDTH-1:0] rem;
   logic space;
   assign space = !out_vld | out_rdy;
   assign fifo_rd_en = (state == HDR) ? !fifo_empty : (!fifo_empty & space);
   assign busy = (state == PAY);
`ifdef PKT_TIMEOUT_EN
   localparam int STV_W = $clog2(TIMEOUT_CYC + 1);
   logic [STV_W-1:0] stv;
`else
   assign timeout_err = TIMEOUT_CYC < 0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HDR;
         rem        <= '0;
         out_dt     <= '0;
         out_vld    <= 1'b0;
         out_last   <= 1'b0;
         pkt_cnt    <= '0;
         drop_pulse <= 1'b0;
`ifdef PKT_TIMEOUT_EN
         timeout_err <= 1'b0;
         stv         <= '0;
`endif
      end else begin
         drop_pulse <= 1'b0;
         if (out_vld & out_rdy) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            if (out_last) pkt_cnt <= pkt_cnt + 1'b1;
         end
         if (state == HDR) begin
            if (fifo_rd_en) begin
               if (fifo_rd_dt == '0) drop_pulse <= 1'b1;
               else begin
                  rem   <= fifo_rd_dt;
                  state <= PAY;
               end
            end
         end else if (fifo_rd_en) begin
            out_dt   <= fifo_rd_dt;
            out_vld  <= 1'b1;
            out_last <= (rem == DT_WIDTH'(1));
            rem      <= rem - 1'b1;
            if (rem == DT_WIDTH'(1)) state <= HDR;
         end
`ifdef PKT_TIMEOUT_EN
         timeout_err <= 1'b0;
         // the abort overrides the PAY state update above; the output register is left to drain
         if (state != PAY || fifo_rd_en) stv <= '0;
         else if (fifo_empty) begin
            if (stv == STV_W'(TIMEOUT_CYC - 1)) begin
               timeout_err <= 1'b1;
               state       <= HDR;
               rem         <= '0;
               stv         <= '0;
            end else stv <= stv + 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: FIFO model feeding the reader, scoreboard on the output stream.
// Builds with or without PKT_TIMEOUT_EN; the starvation test adapts to the build.
module tb_fifo_pkt_reader;
   logic clk = 1'b0, rst = 1'b1, out_rdy = 1'b1;
   logic fifo_empty, fifo_rd_en, out_vld, out_last, busy, drop_pulse, timeout_err;
   logic [7:0] fifo_rd_dt, out_dt;
   logic [15:0] pkt_cnt;
   logic [7:0] mem [256];
   int rd_ptr = 0, wr_ptr = 0, rd_count = 0;
   int errors = 0, checks = 0, vld_cnt = 0, drop_cnt = 0, tmo_cnt = 0;
   typedef struct {logic [7:0] d; logic l;} exp_t;
   exp_t exp_q[$];
   logic prev_hold = 1'b0;
   logic [7:0] prev_dt = '0;

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_rd_dt = mem[rd_ptr[7:0]];

   fifo_pkt_reader #(.DT_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_dt(fifo_rd_dt),
      .fifo_rd_en(fifo_rd_en), .out_dt(out_dt), .out_vld(out_vld), .out_last(out_last),
      .out_rdy(out_rdy), .busy(busy), .drop_pulse(drop_pulse), .timeout_err(timeout_err),
      .pkt_cnt(pkt_cnt));

   always @(posedge clk) if (fifo_rd_en && !fifo_empty) begin
      rd_ptr   <= rd_ptr + 1;
      rd_count <= rd_count + 1;
   end

   // output monitor and scoreboard
   always @(negedge clk) begin
      if (fifo_rd_en && fifo_empty) begin
         errors++;
         $display("FAIL rd_when_empty: fifo_rd_en=1 while fifo_empty=1 at %0t", $time);
      end
      if (prev_hold) begin
         checks++;
         if (out_vld !== 1'b1 || out_dt !== prev_dt) begin
            errors++;
            $display("FAIL hold: out_vld=%b out_dt=%h, required 1/%h", out_vld, out_dt, prev_dt);
         end
      end
      prev_hold = out_vld && !out_rdy && !rst;
      prev_dt   = out_dt;
      if (out_vld) vld_cnt++;
      if (drop_pulse) drop_cnt++;
      if (timeout_err) tmo_cnt++;
      if (out_vld && out_rdy && !rst) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_word: got %h last=%b, none expected", out_dt, out_last);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_dt !== e.d || out_last !== e.l) begin
               errors++;
               $display("FAIL word: got %h last=%b, required %h last=%b", out_dt, out_last, e.d, e.l);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      mem[wr_ptr[7:0]] = v;
      wr_ptr++;
   endtask

   task automatic expect_word(input logic [7:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name, input int n);
      logic done = 1'b0;
      for (int i = 0; i < n && !done; i++) begin
         @(negedge clk);
         done = exp_q.size() == 0 && !out_vld && fifo_empty && !busy;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout: pending=%0d busy=%b, required drained", name, exp_q.size(), busy);
      end
   endtask

   task automatic wait_reads(input string name, input int target);
      logic done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         done = rd_count >= target;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_reads: rd_count=%0d, required %0d", name, rd_count, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_vld, out_last, busy, drop_pulse, timeout_err, fifo_rd_en} !== 6'b0 || pkt_cnt !== 16'd0 || out_dt !== 8'd0) begin
         errors++;
         $display("FAIL reset: vld=%b last=%b busy=%b drop=%b tmo=%b rd_en=%b cnt=%0d dt=%h, required all 0",
                  out_vld, out_last, busy, drop_pulse, timeout_err, fifo_rd_en, pkt_cnt, out_dt);
      end
   endtask

   task automatic test_basic();
      int r0 = rd_count, v0 = vld_cnt;
      step();
      out_rdy = 1'b1;
      push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
      expect_word(8'hA1, 0); expect_word(8'hA2, 0); expect_word(8'hA3, 1);
      wait_done("basic", 20);
      checks++;
      if (rd_count - r0 !== 4) begin
         errors++;
         $display("FAIL basic_reads: got %0d, required 4", rd_count - r0);
      end
      checks++;
      if (vld_cnt - v0 !== 3) begin
         errors++;
         $display("FAIL basic_vld_cycles: got %0d, required 3", vld_cnt - v0);
      end
      checks++;
      if (pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt);
      end
   endtask

   task automatic test_stall();
      int r0 = rd_count;
      step();
      out_rdy = 1'b0;
      push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
      expect_word(8'hA1, 0); expect_word(8'hA2, 0); expect_word(8'hA3, 1);
      wait_reads("stall", r0 + 2);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_vld !== 1'b1 || out_dt !== 8'hA1 || rd_count - r0 !== 2) begin
            errors++;
            $display("FAIL stall_hold: vld=%b dt=%h reads=%0d, required 1/a1/2", out_vld, out_dt, rd_count - r0);
         end
         if (i < 4) @(negedge clk);
      end
      step();
      out_rdy = 1'b1;
      wait_done("stall", 20);
      checks++;
      if (pkt_cnt !== 16'd2) begin
         errors++;
         $display("FAIL stall_pkt_cnt: got %0d, required 2", pkt_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = drop_cnt;
      logic [15:0] c0 = pkt_cnt;
      step();
      push(8'h00); push(8'h02); push(8'hB1); push(8'hB2); push(8'h01); push(8'hC1);
      expect_word(8'hB1, 0); expect_word(8'hB2, 1); expect_word(8'hC1, 1);
      wait_done("b2b", 30);
      checks++;
      if (drop_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL b2b_drop: got %0d cycles, required 1", drop_cnt - d0);
      end
      checks++;
      if (pkt_cnt !== c0 + 16'd2) begin
         errors++;
         $display("FAIL b2b_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 16'd2);
      end
   endtask

   task automatic test_mid_reset();
      int r0 = rd_count;
      step();
      push(8'h05); push(8'hD1); push(8'hD2);
      expect_word(8'hD1, 0); expect_word(8'hD2, 0);
      wait_reads("midrst", r0 + 3);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0 || pkt_cnt !== 16'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midrst_state: vld=%b cnt=%0d busy=%b pending=%0d, required 0/0/0/0",
                  out_vld, pkt_cnt, busy, exp_q.size());
      end
      step();
      push(8'h01); push(8'hE1);
      expect_word(8'hE1, 1);
      wait_done("midrst", 20);
      checks++;
      if (pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL midrst_pkt_cnt: got %0d, required 1", pkt_cnt);
      end
   endtask

`ifdef PKT_TIMEOUT_EN
   task automatic test_timeout();
      int r0 = rd_count, first = -1, t0 = tmo_cnt;
      logic [15:0] c0 = pkt_cnt;
      step();
      push(8'h04); push(8'hF1);
      expect_word(8'hF1, 0);
      wait_reads("tmo", r0 + 2);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (timeout_err && first < 0) first = i;
      end
      checks++;
      if (first != 8 || tmo_cnt - t0 != 1) begin
         errors++;
         $display("FAIL tmo_pulse: first at %0d count %0d, required 8/1", first, tmo_cnt - t0);
      end
      checks++;
      if (busy !== 1'b0 || pkt_cnt !== c0) begin
         errors++;
         $display("FAIL tmo_state: busy=%b cnt=%0d, required 0/%0d", busy, pkt_cnt, c0);
      end
      step();
      push(8'h01); push(8'h61);
      expect_word(8'h61, 1);
      wait_done("tmo", 20);
      checks++;
      if (pkt_cnt !== c0 + 16'd1) begin
         errors++;
         $display("FAIL tmo_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 16'd1);
      end
   endtask
`else
   task automatic test_no_timeout();
      int r0 = rd_count, t0 = tmo_cnt;
      logic [15:0] c0 = pkt_cnt;
      step();
      push(8'h04); push(8'hF1);
      expect_word(8'hF1, 0); expect_word(8'hF2, 0); expect_word(8'hF3, 0); expect_word(8'hF4, 1);
      wait_reads("notmo", r0 + 2);
      repeat (40) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || tmo_cnt != t0) begin
         errors++;
         $display("FAIL notmo_wait: busy=%b tmo_cycles=%0d, required 1/0", busy, tmo_cnt - t0);
      end
      step();
      push(8'hF2); push(8'hF3); push(8'hF4);
      wait_done("notmo", 20);
      checks++;
      if (pkt_cnt !== c0 + 16'd1) begin
         errors++;
         $display("FAIL notmo_pkt_cnt: got %0d, required %0d", pkt_cnt, c0 + 16'd1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_mid_reset();
`ifdef PKT_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d words never seen", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
